sc_game_field: RTL and testbench



---
 rtl/sc_game_field_pkg.sv | 28 ++
 rtl/sc_edge_detect.sv | 29 ++
 rtl/sc_game_field.sv | 208 ++++++++++++++++++++
 tb/tb_sc_game_field.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_game_field_pkg.sv
// Shared constants for the game-field block: state encoding, IDLE arrow
// artwork, obstacle LFSR tap mask and the obstacle column decoder.
package sc_game_field_pkg;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_PLAY     = 2'b01;
  localparam logic [1:0] ST_GAMEOVER = 2'b10;

  // Arrow shown while waiting for start; row 0 is the player row.
  localparam logic [7:0] IDLE_ROW7 = 8'h10;
  localparam logic [7:0] IDLE_ROW6 = 8'h38;
  localparam logic [7:0] IDLE_ROW5 = 8'h7C;
  localparam logic [7:0] IDLE_ROW4 = 8'h7C;
  localparam logic [7:0] IDLE_ROW3 = 8'h38;
  localparam logic [7:0] IDLE_ROW2 = 8'h10;
  localparam logic [7:0] IDLE_ROW1 = 8'h00;
  localparam logic [7:0] IDLE_ROW0 = 8'h10;

  // Fibonacci taps 8,6,5,4 (bits 7,5,4,3); maximal length, so a non-zero
  // seed never reaches the all-zero lock-up state.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Column index to one-hot obstacle pattern.
  function automatic logic [7:0] oneHot8(input logic [2:0] idx);
    oneHot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/sc_edge_detect.sv
// Registered single-edge detector. Emits a one-cycle pulse one clock after
// the selected edge of `level`. History clears on reset so no edge is
// reported in the first cycle after reset.
module sc_edge_detect #(
  parameter bit FALLING = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic levelQ;
  logic pulseQ;

  // Track previous level and register the detected edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      levelQ <= 1'b0;
      pulseQ <= 1'b0;
    end else begin
      levelQ <= level;
      pulseQ <= FALLING ? (levelQ & ~level) : (level & ~levelQ);
    end
  end

  assign pulse = pulseQ;

endmodule

// File: rtl/sc_game_field.sv
// Game-field register bank and play FSM for the 8x8 matrix. Holds the
// player row, the falling obstacle rows, the score and the obstacle LFSR,
// and decodes the eight displayed rows purely from registered state.
module sc_game_field
  import sc_game_field_pkg::*;
#(
  parameter int unsigned              DATAWIDTH_BUS = 8,
  parameter logic [7:0]               LFSR_SEED     = 8'hA5,
  parameter logic [DATAWIDTH_BUS-1:0] PLAYER_INIT   = 8'b0001_0000
) (
  input  logic                     SC_GAMEFIELD_CLOCK_50,
  input  logic                     SC_GAMEFIELD_RESET_InHigh,
  input  logic                     SC_GAMEFIELD_start_In,
  input  logic                     SC_GAMEFIELD_left_In,
  input  logic                     SC_GAMEFIELD_right_In,
  input  logic                     SC_GAMEFIELD_T0_InLow,
  output logic                     SC_GAMEFIELD_upcount_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data7_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data6_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data5_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data4_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data3_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data2_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data1_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data0_OutBUS,
  output logic [7:0]               SC_GAMEFIELD_score_OutBUS,
  output logic [1:0]               SC_GAMEFIELD_state_OutBUS,
  output logic                     SC_GAMEFIELD_gameover_Out
);

  localparam int unsigned NumRows = 8;

  logic clock;
  logic reset;
  assign clock = SC_GAMEFIELD_CLOCK_50;
  assign reset = SC_GAMEFIELD_RESET_InHigh;

  // ---------------------------------------------------------------------------
  // Input edge detection
  // ---------------------------------------------------------------------------
  logic startRise;
  logic leftRise;
  logic rightRise;
  logic tick;

  sc_edge_detect #(.FALLING(1'b0)) uStartEdge (
    .clock (clock),
    .reset (reset),
    .level (SC_GAMEFIELD_start_In),
    .pulse (startRise)
  );

  sc_edge_detect #(.FALLING(1'b0)) uLeftEdge (
    .clock (clock),
    .reset (reset),
    .level (SC_GAMEFIELD_left_In),
    .pulse (leftRise)
  );

  sc_edge_detect #(.FALLING(1'b0)) uRightEdge (
    .clock (clock),
    .reset (reset),
    .level (SC_GAMEFIELD_right_In),
    .pulse (rightRise)
  );

  // Tick is active-low; a held-low level yields a single tick.
  sc_edge_detect #(.FALLING(1'b1)) uTickEdge (
    .clock (clock),
    .reset (reset),
    .level (SC_GAMEFIELD_T0_InLow),
    .pulse (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]               stateQ,   stateD;
  logic [DATAWIDTH_BUS-1:0] playerQ,  playerD;
  logic [DATAWIDTH_BUS-1:0] obsQ [NumRows];
  logic [DATAWIDTH_BUS-1:0] obsD [NumRows];
  logic [7:0]               scoreQ,   scoreD;
  logic [7:0]               lfsrQ,    lfsrD;
  // High when the next applied tick is an odd-numbered one (spawns a block).
  logic                     oddTickQ, oddTickD;

  logic collision;
  assign collision = |(playerQ & obsQ[0]);

  // Next-state logic for FSM, player, obstacle rows, score and LFSR.
  always_comb begin
    stateD   = stateQ;
    playerD  = playerQ;
    scoreD   = scoreQ;
    oddTickD = oddTickQ;
    for (int k = 0; k < NumRows; k++) begin
      obsD[k] = obsQ[k];
    end
    lfsrD = {lfsrQ[6:0], ^(lfsrQ & LFSR_TAPS)};

    case (stateQ)
      ST_IDLE: begin
        if (startRise) begin
          stateD   = ST_PLAY;
          playerD  = PLAYER_INIT;
          scoreD   = 8'h00;
          oddTickD = 1'b1;
          for (int k = 0; k < NumRows; k++) begin
            obsD[k] = '0;
          end
        end
      end

      ST_PLAY: begin
        if (collision) begin
          // Freeze the field exactly as it was when the hit happened.
          stateD = ST_GAMEOVER;
        end else begin
          if (leftRise && !rightRise && !playerQ[DATAWIDTH_BUS-1]) begin
            playerD = playerQ << 1;
          end else if (rightRise && !leftRise && !playerQ[0]) begin
            playerD = playerQ >> 1;
          end

          if (tick) begin
            for (int k = 0; k < NumRows - 1; k++) begin
              obsD[k] = obsQ[k+1];
            end
            obsD[NumRows-1] = oddTickQ ? DATAWIDTH_BUS'(oneHot8(lfsrQ[2:0])) : '0;
            oddTickD        = ~oddTickQ;
            scoreD          = (scoreQ == 8'hFF) ? scoreQ : scoreQ + 8'd1;
          end
        end
      end

      ST_GAMEOVER: begin
        if (startRise) begin
          stateD = ST_IDLE;
        end
      end

      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ   <= ST_IDLE;
      playerQ  <= PLAYER_INIT;
      scoreQ   <= 8'h00;
      lfsrQ    <= LFSR_SEED;
      oddTickQ <= 1'b1;
      for (int k = 0; k < NumRows; k++) begin
        obsQ[k] <= '0;
      end
    end else begin
      stateQ   <= stateD;
      playerQ  <= playerD;
      scoreQ   <= scoreD;
      lfsrQ    <= lfsrD;
      oddTickQ <= oddTickD;
      for (int k = 0; k < NumRows; k++) begin
        obsQ[k] <= obsD[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH_BUS-1:0] rowOut [NumRows];

  // Arrow artwork in IDLE, live or frozen field otherwise.
  always_comb begin
    for (int k = 0; k < NumRows; k++) begin
      rowOut[k] = obsQ[k];
    end
    if (stateQ == ST_IDLE) begin
      rowOut[7] = DATAWIDTH_BUS'(IDLE_ROW7);
      rowOut[6] = DATAWIDTH_BUS'(IDLE_ROW6);
      rowOut[5] = DATAWIDTH_BUS'(IDLE_ROW5);
      rowOut[4] = DATAWIDTH_BUS'(IDLE_ROW4);
      rowOut[3] = DATAWIDTH_BUS'(IDLE_ROW3);
      rowOut[2] = DATAWIDTH_BUS'(IDLE_ROW2);
      rowOut[1] = DATAWIDTH_BUS'(IDLE_ROW1);
      rowOut[0] = DATAWIDTH_BUS'(IDLE_ROW0);
    end else begin
      rowOut[0] = playerQ | obsQ[0];
    end
  end

  assign SC_GAMEFIELD_data7_OutBUS   = rowOut[7];
  assign SC_GAMEFIELD_data6_OutBUS   = rowOut[6];
  assign SC_GAMEFIELD_data5_OutBUS   = rowOut[5];
  assign SC_GAMEFIELD_data4_OutBUS   = rowOut[4];
  assign SC_GAMEFIELD_data3_OutBUS   = rowOut[3];
  assign SC_GAMEFIELD_data2_OutBUS   = rowOut[2];
  assign SC_GAMEFIELD_data1_OutBUS   = rowOut[1];
  assign SC_GAMEFIELD_data0_OutBUS   = rowOut[0];
  assign SC_GAMEFIELD_score_OutBUS   = scoreQ;
  assign SC_GAMEFIELD_state_OutBUS   = stateQ;
  assign SC_GAMEFIELD_gameover_Out   = (stateQ == ST_GAMEOVER);
  assign SC_GAMEFIELD_upcount_OutLow = (stateQ != ST_PLAY);

endmodule

// File: tb/tb_sc_game_field.sv
// Directed self-checking bench for sc_game_field. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_sc_game_field;

  logic       clk;
  logic       rst;
  logic       start;
  logic       left;
  logic       right;
  logic       t0;
  logic       upcount;
  logic [7:0] d7, d6, d5, d4, d3, d2, d1, d0;
  logic [7:0] score;
  logic [1:0] state;
  logic       gameover;

  int errors = 0;
  int checks = 0;

  // Reference model of the field.
  logic [7:0] expPlayer;
  logic [7:0] expObs [8];
  int         expScore;
  bit         expOdd;

  // Reference LFSR; lfsrPrev holds the value the DUT used at the last edge.
  logic [7:0] lfsrM;
  logic [7:0] lfsrPrev;

  sc_game_field dut (
    .SC_GAMEFIELD_CLOCK_50       (clk),
    .SC_GAMEFIELD_RESET_InHigh   (rst),
    .SC_GAMEFIELD_start_In       (start),
    .SC_GAMEFIELD_left_In        (left),
    .SC_GAMEFIELD_right_In       (right),
    .SC_GAMEFIELD_T0_InLow       (t0),
    .SC_GAMEFIELD_upcount_OutLow (upcount),
    .SC_GAMEFIELD_data7_OutBUS   (d7),
    .SC_GAMEFIELD_data6_OutBUS   (d6),
    .SC_GAMEFIELD_data5_OutBUS   (d5),
    .SC_GAMEFIELD_data4_OutBUS   (d4),
    .SC_GAMEFIELD_data3_OutBUS   (d3),
    .SC_GAMEFIELD_data2_OutBUS   (d2),
    .SC_GAMEFIELD_data1_OutBUS   (d1),
    .SC_GAMEFIELD_data0_OutBUS   (d0),
    .SC_GAMEFIELD_score_OutBUS   (score),
    .SC_GAMEFIELD_state_OutBUS   (state),
    .SC_GAMEFIELD_gameover_Out   (gameover)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) begin
      lfsrM    <= 8'hA5;
      lfsrPrev <= 8'hA5;
    end else begin
      lfsrPrev <= lfsrM;
      lfsrM    <= {lfsrM[6:0], lfsrM[7] ^ lfsrM[5] ^ lfsrM[4] ^ lfsrM[3]};
    end
  end

  function automatic logic [7:0] getRow(input int k);
    case (k)
      0: getRow = d0;
      1: getRow = d1;
      2: getRow = d2;
      3: getRow = d3;
      4: getRow = d4;
      5: getRow = d5;
      6: getRow = d6;
      default: getRow = d7;
    endcase
  endfunction

  function automatic logic [7:0] idleRow(input int k);
    case (k)
      0: idleRow = 8'h10;
      1: idleRow = 8'h00;
      2: idleRow = 8'h10;
      3: idleRow = 8'h38;
      4: idleRow = 8'h7C;
      5: idleRow = 8'h7C;
      6: idleRow = 8'h38;
      default: idleRow = 8'h10;
    endcase
  endfunction

  function automatic logic [7:0] expRow(input int k);
    expRow = (k == 0) ? (expPlayer | expObs[0]) : expObs[k];
  endfunction

  // 0 start, 1 left, 2 right, 3 left+right, 4 T0 low; effect visible on return.
  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: left  = 1'b1;
      2: right = 1'b1;
      3: begin left = 1'b1; right = 1'b1; end
      default: t0 = 1'b0;
    endcase
    @(negedge clk);
    start = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    t0    = 1'b1;
    @(negedge clk);
  endtask

  task automatic modelInit();
    expPlayer = 8'h10;
    for (int k = 0; k < 8; k++) expObs[k] = 8'h00;
    expScore = 0;
    expOdd   = 1'b1;
  endtask

  // Call on the sample edge right after the tick was applied.
  task automatic modelTick();
    for (int k = 0; k < 7; k++) expObs[k] = expObs[k+1];
    expObs[7] = expOdd ? (8'h01 << lfsrPrev[2:0]) : 8'h00;
    expOdd    = ~expOdd;
    if (expScore < 255) expScore++;
  endtask

  task automatic moveLeft();
    pulse(1);
    if (expPlayer != 8'h80) expPlayer = expPlayer << 1;
  endtask

  task automatic moveRight();
    pulse(2);
    if (expPlayer != 8'h01) expPlayer = expPlayer >> 1;
  endtask

  // Step aside if the next tick would drop a block on the player, then tick.
  task automatic dodgeAndTick();
    if ((expPlayer & expObs[1]) != 8'h00) begin
      if (expPlayer != 8'h80) moveLeft();
      else moveRight();
    end
    pulse(4);
    modelTick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (state !== 2'b00) begin
      errors++; $display("FAIL reset_state: got %b expected 00", state);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (getRow(k) !== idleRow(k)) begin
        errors++; $display("FAIL reset_row%0d: got %h expected %h", k, getRow(k), idleRow(k));
      end
    end
    checks++;
    if (upcount !== 1'b1 || gameover !== 1'b0 || score !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: got upcount=%b gameover=%b score=%h expected 1 0 00",
               upcount, gameover, score);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state !== 2'b00) begin
      errors++; $display("FAIL start_latency: got %b expected 00 one cycle after edge", state);
    end
    @(negedge clk);
    modelInit();
    checks++;
    if (state !== 2'b01 || upcount !== 1'b0) begin
      errors++; $display("FAIL start_play: got state=%b upcount=%b expected 01 0", state, upcount);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (getRow(k) !== expRow(k)) begin
        errors++; $display("FAIL start_row%0d: got %h expected %h", k, getRow(k), expRow(k));
      end
    end
    pulse(0);
    checks++;
    if (state !== 2'b01 || d0 !== 8'h10) begin
      errors++; $display("FAIL start_in_play: got state=%b d0=%h expected 01 10", state, d0);
    end
  endtask

  task automatic test_move();
    moveLeft();
    checks++;
    if (d0 !== 8'h20) begin
      errors++; $display("FAIL move_left1: got %h expected 20", d0);
    end
    repeat (4) moveLeft();
    checks++;
    if (d0 !== 8'h80) begin
      errors++; $display("FAIL move_left_sat: got %h expected 80", d0);
    end
    repeat (8) moveRight();
    checks++;
    if (d0 !== 8'h01) begin
      errors++; $display("FAIL move_right_sat: got %h expected 01", d0);
    end
    pulse(3);
    checks++;
    if (d0 !== 8'h01 || expPlayer !== 8'h01) begin
      errors++; $display("FAIL move_both: got %h expected 01", d0);
    end
  endtask

  task automatic test_ticks();
    t0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    modelTick();
    repeat (18) @(negedge clk);
    t0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (score !== 8'd1) begin
      errors++; $display("FAIL tick_held_low: got score=%0d expected 1", score);
    end
    checks++;
    if ($countones(d7) != 1) begin
      errors++; $display("FAIL tick_row7_odd1: got %h expected one-hot", d7);
    end
    for (int t = 2; t <= 8; t++) begin
      dodgeAndTick();
      checks++;
      if ((t % 2 == 1) ? ($countones(d7) != 1) : (d7 !== 8'h00)) begin
        errors++; $display("FAIL tick_row7_parity t=%0d: got %h", t, d7);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (getRow(k) !== expRow(k)) begin
          errors++;
          $display("FAIL tick_shift t=%0d row%0d: got %h expected %h", t, k, getRow(k), expRow(k));
        end
      end
    end
    checks++;
    if (score !== 8'd8 || state !== 2'b01) begin
      errors++; $display("FAIL tick_total: got score=%0d state=%b expected 8 01", score, state);
    end
  endtask

  task automatic test_collision();
    bit hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (expObs[1] != 8'h00) begin
        for (int m = 0; m < 8 && expPlayer != expObs[1]; m++) begin
          if (expObs[1] > expPlayer) moveLeft();
          else moveRight();
        end
        pulse(4);
        modelTick();
        hit = 1'b1;
        checks++;
        if (state !== 2'b01 || d0 !== expRow(0)) begin
          errors++;
          $display("FAIL hit_overlap: got state=%b d0=%h expected 01 %h", state, d0, expRow(0));
        end
        @(negedge clk);
        checks++;
        if (state !== 2'b10 || gameover !== 1'b1 || upcount !== 1'b1) begin
          errors++;
          $display("FAIL hit_gameover: got state=%b gameover=%b upcount=%b expected 10 1 1",
                   state, gameover, upcount);
        end
      end else begin
        pulse(4);
        modelTick();
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL hit_reach: got no obstacle in 20 ticks expected one");
    end
    pulse(4);
    pulse(1);
    pulse(2);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (getRow(k) !== expRow(k)) begin
        errors++; $display("FAIL frozen_row%0d: got %h expected %h", k, getRow(k), expRow(k));
      end
    end
    checks++;
    if (score !== 8'(expScore) || state !== 2'b10) begin
      errors++;
      $display("FAIL frozen_score: got score=%0d state=%b expected %0d 10", score, state, expScore);
    end
    pulse(0);
    checks++;
    if (state !== 2'b00 || gameover !== 1'b0 || d6 !== 8'h38) begin
      errors++;
      $display("FAIL gameover_to_idle: got state=%b gameover=%b d6=%h expected 00 0 38",
               state, gameover, d6);
    end
  endtask

  task automatic test_reset_mid_play();
    pulse(0);
    modelInit();
    repeat (3) dodgeAndTick();
    checks++;
    if (score !== 8'd3 || state !== 2'b01) begin
      errors++; $display("FAIL midreset_pre: got score=%0d state=%b expected 3 01", score, state);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'b00 || score !== 8'h00 || upcount !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got state=%b score=%h upcount=%b expected 00 00 1",
               state, score, upcount);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (getRow(k) !== idleRow(k)) begin
        errors++; $display("FAIL midreset_row%0d: got %h expected %h", k, getRow(k), idleRow(k));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    t0    = 1'b1;
    modelInit();
    @(negedge clk);
    test_reset();
    test_start();
    test_move();
    test_ticks();
    test_collision();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
